// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-mode shifter (SRL/SLL/SRA/ROR) with valid/ready
// handshakes on input and output.
// Default build shifts one bit position per enabled clock.
// Optional macro SHIFT_UNIT_BARREL_EN: a log2 barrel network loads the final
// result at the accept edge, and the SHIFT state is never entered.
module shift_unit_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned AMT_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     d,
  input  logic [AMT_N-1:0] amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {M_SRL, M_SLL, M_SRA, M_ROR} mode_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [AMT_N-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;

  // Move the operand by a single bit position according to the mode.
  function automatic logic [N-1:0] step1(input logic [N-1:0] x, input mode_e m);
    case (m)
      M_SRL:   step1 = {1'b0, x[N-1:1]};
      M_SLL:   step1 = {x[N-2:0], 1'b0};
      M_SRA:   step1 = {x[N-1], x[N-1:1]};
      default: step1 = {x[0], x[N-1:1]};
    endcase
  endfunction

`ifdef SHIFT_UNIT_BARREL_EN
  // Shift by a fixed stage distance k; distances >= N saturate the same way
  // repeated single steps would (zeros, sign fill, or rotate modulo N).
  function automatic logic [N-1:0] shift_k(input logic [N-1:0] x, input mode_e m,
                                           input int unsigned k);
    int unsigned r;
    r = k % N;
    case (m)
      M_SRL:   shift_k = x >> k;
      M_SLL:   shift_k = x << k;
      M_SRA:   shift_k = $signed(x) >>> k;
      default: shift_k = (r == 0) ? x : ((x >> r) | (x << (N - r)));
    endcase
  endfunction

  // Log2 network: stage i applies a shift of 2**i when amt bit i is set.
  function automatic logic [N-1:0] barrel(input logic [N-1:0] x,
                                          input logic [AMT_N-1:0] a,
                                          input mode_e m);
    logic [N-1:0]     v;
    logic [AMT_N-1:0] rem;
    v   = x;
    rem = a;
    for (int unsigned i = 0; i < AMT_N; i++) begin
      if (rem[0]) v = shift_k(v, m, 32'd1 << i);
      rem = rem >> 1;
    end
    return v;
  endfunction
`endif

  // State and datapath registers; asynchronous reset, all updates gated by en via _d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= M_SRL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath update: accept, iterate, release on output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_d = mode_e'(mode);
`ifdef SHIFT_UNIT_BARREL_EN
            acc_d   = barrel(d, amt, mode_e'(mode));
            cnt_d   = '0;
            state_d = DONE;
`else
            acc_d   = d;
            cnt_d   = amt;
            state_d = (amt == '0) ? DONE : SHIFT;
`endif
          end
        end
        SHIFT: begin
          acc_d = step1(acc_q, mode_q);
          cnt_d = cnt_q - AMT_N'(1);
          if (cnt_q == AMT_N'(1)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE) && en;
    out_valid = (state_q == DONE);
    out       = acc_q;
`ifdef SHIFT_UNIT_BARREL_EN
    busy      = 1'b0;
`else
    busy      = (state_q == SHIFT);
`endif
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed testbench for shift_unit_seq (N=8, AMT_N=3); expectations are
// hand-computed, with latency expectations switched by SHIFT_UNIT_BARREL_EN.
module tb_shift_unit_seq;

`ifdef SHIFT_UNIT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic [2:0] amt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] SRL = 2'b00, SLL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  shift_unit_seq #(.N(8), .AMT_N(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .amt(amt), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an operand at a negedge; it is accepted on the following posedge.
  task automatic accept(input logic [7:0] dv, input logic [2:0] av, input logic [1:0] mv);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    d = dv; amt = av; mode = mv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d = 8'h3C; amt = 3'd6; mode = ~mv;
  endtask

  // Count negedges after the accept edge until out_valid (lat=1 means after edge k).
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end while (!out_valid && lat < 50);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_cleared"}, out_valid, 1'b0);
    check({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] dv, input logic [2:0] av,
                        input logic [1:0] mv, input logic [7:0] exp);
    int lat, bc;
    accept(dv, av, mv);
    wait_valid(lat, bc);
    check({tag, "_latency"}, lat, BARREL ? 1 : av + 1);
    check({tag, "_busy_cycles"}, bc, BARREL ? 0 : av);
    check({tag, "_out"}, out, exp);
    handshake(tag);
  endtask

  initial begin
    int lat, bc;
    logic [7:0] held;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    d = '0; amt = '0; mode = '0;
    #12;
    check("reset_out", out, 8'h00);
    check("reset_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    #5 rst = 1'b0;

    // Main function across modes, including amt=0 and amounts near N.
    run_op("srl3", 8'hB6, 3'd3, SRL, 8'h16);
    run_op("sra3", 8'hB6, 3'd3, SRA, 8'hF6);
    run_op("sll3", 8'hB6, 3'd3, SLL, 8'hB0);
    run_op("ror3", 8'hB6, 3'd3, ROR, 8'hD6);
    run_op("amt0_sra", 8'hA5, 3'd0, SRA, 8'hA5);
    run_op("amt0_ror", 8'hA5, 3'd0, ROR, 8'hA5);
    run_op("srl7", 8'hFF, 3'd7, SRL, 8'h01);
    run_op("sra7", 8'h80, 3'd7, SRA, 8'hFF);
    run_op("sll7", 8'hFF, 3'd7, SLL, 8'h80);
    run_op("ror7", 8'hB6, 3'd7, ROR, 8'h6D);

    // Backpressure in DONE: output stable, input pulses ignored, en=0 blocks handshake.
    accept(8'h5A, 3'd2, SLL);
    wait_valid(lat, bc);
    check("bp_out", out, 8'h68);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      d = 8'hFF;
      amt = 3'd0;
      @(negedge clk);
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_out_held", out, 8'h68);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("en_low_no_handshake", out_valid, 1'b1);
    out_ready = 1'b0;
    en = 1'b1;
    handshake("bp");

    // Freeze mid-SHIFT: en low for 4 edges delays the result by exactly 4.
    accept(8'hB6, 3'd5, SRL);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3 && !out_valid) en = 1'b0;
      if (lat == 5) begin
        check("freeze_acc", out, BARREL ? 8'h05 : 8'h2D);
        check("freeze_in_ready", in_ready, 1'b0);
      end
      if (lat == 7) en = 1'b1;
    end while (!out_valid && lat < 50);
    en = 1'b1;
    check("freeze_latency", lat, BARREL ? 1 : 10);
    check("freeze_out", out, 8'h05);
    handshake("freeze");

    // Asynchronous reset mid-operation, away from any clock edge.
    accept(8'hB6, 3'd6, SRA);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out", out, 8'h00);
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    run_op("post_rst_ror1", 8'h01, 3'd1, ROR, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
